perceptron_train_ctrl: RTL and testbench
========================================

Name: perceptron_train_ctrl

Overview:
- Training controller and weight datapath for the two-input perceptron.
- Drives the 0-to-199 sample counter through its `load`/`enable` inputs and consumes its terminal-count `cout`.
- Reads samples from a synchronous sample ROM addressed by the counter value and learns w1, w2, b with the perceptron rule, epoch after epoch.
- Stops when an epoch completes with no error or when MAX_EPOCH epochs have run.

Parameters:
- DW, 8: signed sample width for x1, x2.
- WW, 16: signed width of w1, w2 and b.
- MAX_EPOCH, 16: epoch limit; must be at least 1.
- EW, 5: epoch counter width; must hold MAX_EPOCH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin training; sampled only in IDLE and DONE
- cnt_cout  in  1  counter terminal count; high when the counter value is 199
- cnt_ld  out  1  clears the counter to 0
- cnt_en  out  1  advances the counter; 199 wraps to 0
- x1  in  DW  signed sample input 1; ROM data, valid 1 cycle after the counter changes
- x2  in  DW  signed sample input 2; same timing as x1
- t  in  1  target label: 1 means +1, 0 means -1
- w1  out  WW  weight 1, signed
- w2  out  WW  weight 2, signed
- b  out  WW  bias, signed
- epoch  out  EW  number of completed epochs
- busy  out  1  training in progress
- done  out  1  training finished; held until the next start
- converged  out  1  last epoch had zero errors; valid while done=1

Behaviour:
- Reset: state IDLE; w1=w2=b=0; epoch=0; err_flag=0; busy=done=converged=0; cnt_ld=cnt_en=0.
- cnt_ld, cnt_en and busy are Moore decodes of the state. busy=1 in every state except IDLE and DONE.
- States and transitions:
  - IDLE: on start go to INIT.
  - INIT: w1=w2=b=0, epoch=0, err_flag=0, converged=0, done=0; cnt_ld=1 for this one cycle. Next state FETCH.
  - FETCH: wait one cycle for ROM data. Next state EVAL.
  - EVAL:
    - net = w1*x1 + w2*x2 + b, computed full precision, signed, width DW+WW+2; no overflow is possible.
    - y = 1 when net >= 0, otherwise 0.
    - If y != t go to UPDATE, otherwise go to NEXT.
  - UPDATE:
    - With s = +1 if t=1, else -1: w1 += s*x1, w2 += s*x2, b += s.
    - Each result saturates to [-2^(WW-1), 2^(WW-1)-1]; it never wraps.
    - Set err_flag=1. Next state NEXT.
  - NEXT: if cnt_cout=1 go to CHECK; otherwise cnt_en=1 and go to FETCH.
  - CHECK:
    - Increment epoch.
    - If err_flag=0: converged=1, go to DONE.
    - Else if epoch+1 == MAX_EPOCH: converged=0, go to DONE.
    - Otherwise: err_flag=0, cnt_en=1 (counter wraps 199 to 0), go to FETCH.
  - DONE: done=1. Weights and epoch are frozen. On start go to INIT.
- Timing:
  - Each sample takes 3 cycles (FETCH, EVAL, NEXT), or 4 when UPDATE is taken.
  - With start sampled at edge E0, an error-free first epoch reaches DONE at edge E0+602.
- Boundary conditions:
  - start is ignored while busy=1.
  - Exactly one cnt_en pulse per sample transition. No cnt_en in INIT, UPDATE or DONE.
  - rst asserted in any state returns immediately to reset values, including mid-UPDATE. No partial weight write survives.
  - A start arriving in the same cycle as rst is lost.

Decomposition:
- perceptron_pkg holds:
  - the state enum
  - N_SAMPLES = 200
  - a sat_add function, parameterised by width, for saturating signed addition
- One sub-module, perceptron_update_unit: combinational net, y and next-weight computation with saturation. The FSM and registers stay in perceptron_train_ctrl.

Test Plan:
1. All 200 samples x1=10, x2=0, t=1; start -> no UPDATE entered; DONE at E0+602; converged=1, epoch=1, w1=w2=b=0; cnt_en pulsed exactly 199 times.
2. All samples x1=10, x2=0, t=0 -> UPDATE only on sample 0 of epoch 1, giving w1=-10, b=-1. Epoch 2 is error-free, so done=1, converged=1, epoch=2.
3. Non-separable set (x1=100, x2=0, t alternating 1,0), MAX_EPOCH=4 -> done=1, converged=0, epoch=4; counter wraps 199 to 0 on each CHECK.
4. Saturation with WW=8: all samples x1=-128, t=0 -> after sample 0, w1=127 (not -128) and b=-1; then converged=1, epoch=2.
5. rst pulsed during EVAL in epoch 2 of scenario 3 -> next cycle IDLE with all outputs 0. A following start reruns scenario 3 with identical final results.
6. start pulsed while busy -> ignored, no restart. start in DONE -> INIT with one cnt_ld pulse, weights cleared, done dropped.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron training controller.
// sat_add works on a wide signed container and clamps to a caller-chosen width.
package perceptron_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_EVAL,
        S_UPDATE,
        S_NEXT,
        S_CHECK,
        S_DONE
    } state_e;

    localparam int N_SAMPLES = 200;
    localparam int SAT_W     = 32;

    // Callers keep both operands and w well below SAT_W, so the wide sum is exact.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] d,
        input int                      w
    );
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sum = $signed({a[SAT_W-1], a}) + $signed({d[SAT_W-1], d});
        hi  = ($signed((SAT_W+1)'(1)) <<< (w - 1)) - 1;
        lo  = ~hi;
        if (sum > hi)
            return hi[SAT_W-1:0];
        else if (sum < lo)
            return lo[SAT_W-1:0];
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/perceptron_update_unit.sv
// Combinational perceptron math: full-precision net, prediction y and the
// saturated next values of w1, w2 and b for the current sample.
module perceptron_update_unit
    import perceptron_pkg::*;
#(
    parameter int DW = 8,
    parameter int WW = 16
) (
    input  logic signed [WW-1:0] w1_i,
    input  logic signed [WW-1:0] w2_i,
    input  logic signed [WW-1:0] b_i,
    input  logic signed [DW-1:0] x1_i,
    input  logic signed [DW-1:0] x2_i,
    input  logic                 t_i,
    output logic                 y_o,
    output logic [WW-1:0]        w1_o,
    output logic [WW-1:0]        w2_o,
    output logic [WW-1:0]        b_o
);
    localparam int NW = DW + WW + 2;

    logic signed [NW-1:0]    net;
    logic signed [SAT_W-1:0] d1, d2, db;

    always_comb begin
        net  = NW'(w1_i) * NW'(x1_i) + NW'(w2_i) * NW'(x2_i) + NW'(b_i);
        y_o  = (net >= 0);
        d1   = t_i ? SAT_W'(x1_i) : -SAT_W'(x1_i);
        d2   = t_i ? SAT_W'(x2_i) : -SAT_W'(x2_i);
        db   = t_i ? SAT_W'(1) : -SAT_W'(1);
        w1_o = WW'(sat_add(SAT_W'(w1_i), d1, WW));
        w2_o = WW'(sat_add(SAT_W'(w2_i), d2, WW));
        b_o  = WW'(sat_add(SAT_W'(b_i), db, WW));
    end

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Perceptron training FSM: walks the sample counter epoch by epoch, applies
// the perceptron rule on misclassified samples and stops on convergence or epoch limit.
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int DW        = 8,
    parameter int WW        = 16,
    parameter int MAX_EPOCH = 16,
    parameter int EW        = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cnt_cout,
    output logic          cnt_ld,
    output logic          cnt_en,
    input  logic [DW-1:0] x1,
    input  logic [DW-1:0] x2,
    input  logic          t,
    output logic [WW-1:0] w1,
    output logic [WW-1:0] w2,
    output logic [WW-1:0] b,
    output logic [EW-1:0] epoch,
    output logic          busy,
    output logic          done,
    output logic          converged
);
    state_e        state_q, state_d;
    logic [WW-1:0] w1_q, w1_d, w2_q, w2_d, b_q, b_d;
    logic [EW-1:0] epoch_q, epoch_d;
    logic          err_q, err_d, done_q, done_d, conv_q, conv_d;

    logic          y;
    logic [WW-1:0] w1_nxt, w2_nxt, b_nxt;
    logic          last_epoch;

    perceptron_update_unit #(.DW(DW), .WW(WW)) u_upd (
        .w1_i ($signed(w1_q)),
        .w2_i ($signed(w2_q)),
        .b_i  ($signed(b_q)),
        .x1_i ($signed(x1)),
        .x2_i ($signed(x2)),
        .t_i  (t),
        .y_o  (y),
        .w1_o (w1_nxt),
        .w2_o (w2_nxt),
        .b_o  (b_nxt)
    );

    assign last_epoch = ((epoch_q + 1'b1) == EW'(MAX_EPOCH));

    always_comb begin
        state_d = state_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        b_d     = b_q;
        epoch_d = epoch_q;
        err_d   = err_q;
        done_d  = done_q;
        conv_d  = conv_q;
        case (state_q)
            // done/converged drop as soon as a new run is accepted
            S_IDLE, S_DONE: if (start) begin
                state_d = S_INIT;
                done_d  = 1'b0;
                conv_d  = 1'b0;
            end
            S_INIT: begin
                w1_d    = '0;
                w2_d    = '0;
                b_d     = '0;
                epoch_d = '0;
                err_d   = 1'b0;
                done_d  = 1'b0;
                conv_d  = 1'b0;
                state_d = S_FETCH;
            end
            S_FETCH:  state_d = S_EVAL;
            S_EVAL:   state_d = (y != t) ? S_UPDATE : S_NEXT;
            S_UPDATE: begin
                w1_d    = w1_nxt;
                w2_d    = w2_nxt;
                b_d     = b_nxt;
                err_d   = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT:   state_d = cnt_cout ? S_CHECK : S_FETCH;
            S_CHECK: begin
                epoch_d = epoch_q + 1'b1;
                if (!err_q) begin
                    conv_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (last_epoch) begin
                    conv_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            w1_q    <= '0;
            w2_q    <= '0;
            b_q     <= '0;
            epoch_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            b_q     <= b_d;
            epoch_q <= epoch_d;
            err_q   <= err_d;
            done_q  <= done_d;
            conv_q  <= conv_d;
        end
    end

    // The CHECK advance is what wraps the counter from 199 back to 0.
    assign cnt_ld    = (state_q == S_INIT);
    assign cnt_en    = ((state_q == S_NEXT) && !cnt_cout) ||
                       ((state_q == S_CHECK) && err_q && !last_epoch);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign w1        = w1_q;
    assign w2        = w2_q;
    assign b         = b_q;
    assign epoch     = epoch_q;
    assign done      = done_q;
    assign converged = conv_q;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Bench for perceptron_train_ctrl: models the 0..199 counter and sync ROM,
// and checks each run against an epoch/sample-level reference of the learning rule.
module tb_perceptron_train_ctrl;
    localparam int DW = 8, WW = 8, MAX_EPOCH = 4, EW = 5, NS = 200;

    logic          clk = 1'b0;
    logic          rst, start, cnt_cout, cnt_ld, cnt_en, t;
    logic [DW-1:0] x1, x2;
    logic [WW-1:0] w1, w2, b;
    logic [EW-1:0] epoch;
    logic          busy, done, converged;

    perceptron_train_ctrl #(.DW(DW), .WW(WW), .MAX_EPOCH(MAX_EPOCH), .EW(EW)) dut (
        .clk(clk), .rst(rst), .start(start), .cnt_cout(cnt_cout),
        .cnt_ld(cnt_ld), .cnt_en(cnt_en), .x1(x1), .x2(x2), .t(t),
        .w1(w1), .w2(w2), .b(b), .epoch(epoch), .busy(busy),
        .done(done), .converged(converged)
    );

    always #5 clk = ~clk;

    int rom_x1[NS], rom_x2[NS];
    bit rom_t[NS];
    int cnt;
    int en_pulses, ld_pulses;

    always @(posedge clk or posedge rst)
        if (rst) cnt <= 0;
        else if (cnt_ld) cnt <= 0;
        else if (cnt_en) cnt <= (cnt == NS - 1) ? 0 : cnt + 1;
    assign cnt_cout = (cnt == NS - 1);

    always @(posedge clk) begin
        x1 <= DW'(rom_x1[cnt]);
        x2 <= DW'(rom_x2[cnt]);
        t  <= rom_t[cnt];
    end

    always @(posedge clk) begin
        if (cnt_en) en_pulses <= en_pulses + 1;
        if (cnt_ld) ld_pulses <= ld_pulses + 1;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Reference model results
    longint m_w1, m_w2, m_b;
    int     m_ep, m_cyc, m_c1, m_en;
    bit     m_conv;

    function automatic longint clamp(input longint v);
        longint hi = (longint'(1) <<< (WW - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    // Cycle count is edges after the start edge until done is seen high.
    task automatic model();
        longint w1m = 0, w2m = 0, bm = 0, net, s;
        int     cyc = 1;
        bit     err;
        m_conv = 0;
        m_c1   = 0;
        m_ep   = 0;
        for (int e = 1; e <= MAX_EPOCH; e++) begin
            err = 0;
            for (int i = 0; i < NS; i++) begin
                net = w1m * rom_x1[i] + w2m * rom_x2[i] + bm;
                cyc += 3;
                if ((net >= 0) != rom_t[i]) begin
                    s   = rom_t[i] ? 1 : -1;
                    w1m = clamp(w1m + s * rom_x1[i]);
                    w2m = clamp(w2m + s * rom_x2[i]);
                    bm  = clamp(bm + s);
                    cyc++;
                    err = 1;
                end
            end
            if (e == 1) m_c1 = cyc - 1;
            cyc++;
            m_ep = e;
            if (!err) begin
                m_conv = 1;
                break;
            end
        end
        m_w1 = w1m; m_w2 = w2m; m_b = bm;
        m_cyc = cyc;
        m_en  = NS * m_ep - 1;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < NS; i++) begin
            case (mode)
                1: begin rom_x1[i] = 10;   rom_x2[i] = 0; rom_t[i] = 1; end
                2: begin rom_x1[i] = 10;   rom_x2[i] = 0; rom_t[i] = 0; end
                3: begin rom_x1[i] = 100;  rom_x2[i] = 0; rom_t[i] = (i % 2 == 0); end
                4: begin rom_x1[i] = -128; rom_x2[i] = 0; rom_t[i] = 0; end
                5: begin
                    rom_x1[i] = int'($urandom_range(255)) - 128;
                    rom_x2[i] = int'($urandom_range(255)) - 128;
                    rom_t[i]  = (3 * rom_x1[i] - 2 * rom_x2[i] + 5 >= 0);
                end
                default: begin
                    rom_x1[i] = int'($urandom_range(255)) - 128;
                    rom_x2[i] = int'($urandom_range(255)) - 128;
                    rom_t[i]  = 1'($urandom_range(1));
                end
            endcase
        end
    endtask

    task automatic run_case(input string tag, input bit poke);
        int cyc, en0, ld0;
        model();
        @(negedge clk);
        en0 = en_pulses; ld0 = ld_pulses;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk({tag, "_done_drop"}, done, 0);
        chk({tag, "_busy"}, busy, 1);
        cyc = 0;
        while (cyc < 6000) begin
            @(posedge clk); cyc++; #1;
            if (cyc == 1) chk({tag, "_clear"}, {w1, w2, b}, 0);
            if (poke && cyc == 40) start = 1'b1;
            if (cyc == 41) start = 1'b0;
            if (done) break;
        end
        chk({tag, "_cycles"}, cyc, m_cyc);
        chk({tag, "_w1"}, $signed(w1), m_w1);
        chk({tag, "_w2"}, $signed(w2), m_w2);
        chk({tag, "_b"}, $signed(b), m_b);
        chk({tag, "_epoch"}, epoch, m_ep);
        chk({tag, "_conv"}, converged, m_conv);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_en_pulses"}, en_pulses - en0, m_en);
        chk({tag, "_ld_pulses"}, ld_pulses - ld0, 1);
    endtask

    task automatic rst_at(input string tag, input int at_edge);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (at_edge) @(posedge clk);
        #1 chk({tag, "_busy_pre"}, busy, 1);
        rst = 1'b1;
        #1 chk({tag, "_async"}, {busy, done, converged, cnt_en, cnt_ld, epoch, w1, w2, b}, 0);
        @(posedge clk); #1
        chk({tag, "_held"}, {busy, done, converged, cnt_en, cnt_ld, epoch, w1, w2, b}, 0);
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1;
        fill(1);
        repeat (2) @(posedge clk);
        #1 chk("reset_state", {busy, done, converged, cnt_en, cnt_ld, epoch, w1, w2, b}, 0);
        @(negedge clk); start = 1'b0; rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("start_in_rst_lost", busy, 0);

        run_case("s1", 1'b0);
        chk("s1_cycles_abs", m_cyc, 602);
        chk("s1_en_abs", m_en, 199);

        fill(2);
        run_case("s2", 1'b0);
        chk("s2_w1_abs", $signed(w1), -10);
        chk("s2_b_abs", $signed(b), -1);
        chk("s2_epoch_abs", epoch, 2);

        fill(3);
        run_case("s3", 1'b0);
        chk("s3_epoch_abs", epoch, MAX_EPOCH);
        chk("s3_conv_abs", converged, 0);

        model();
        rst_at("rst_upd", 6);
        rst_at("rst_eval", 3 + m_c1);
        run_case("s3_rerun", 1'b0);

        fill(4);
        run_case("s4", 1'b0);
        chk("s4_w1_sat", $signed(w1), 127);
        chk("s4_b_abs", $signed(b), -1);

        for (int r = 0; r < 4; r++) begin
            fill((r % 2 == 0) ? 5 : 6);
            run_case($sformatf("rnd%0d", r), r == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
